// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package shift_add_multiplier_pkg;

    // Controller states: waiting for operands, iterating, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operand width used when the instantiating level does not override it.
    localparam int DEFAULT_DATA_W = 8;

    // Reference product for checking the iterative datapath (operands up to 32 bits).
    function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

endpackage : shift_add_multiplier_pkg

// File: rtl/shift_add_multiplier_if.sv
// Operand/result handshake bundle for the shift-and-add multiplier.
// Signal names are from the multiplier's point of view (i_ = into it).
interface shift_add_multiplier_if
    import shift_add_multiplier_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_W-1:0]     i_multiplicand;
    logic [DATA_W-1:0]     i_multiplier;
    logic                  o_valid;
    logic                  i_ready;
    logic [2*DATA_W-1:0]   o_product;

    // Multiplier side: consumes operands, produces the product.
    modport slave (
        input  i_valid,
        input  i_multiplicand,
        input  i_multiplier,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_product
    );

    // Requester side: drives operands, accepts the product.
    modport master (
        output i_valid,
        output i_multiplicand,
        output i_multiplier,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_product
    );
endinterface : shift_add_multiplier_if

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per clock,
// fixed DATA_W-cycle latency, valid/ready handshake on operands and result.
// The work register is {hi, lo}; the add carry exists only combinationally
// because after each right shift it is always shifted back into hi.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    shift_add_multiplier_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_product;
    logic                r_ready;
    logic                r_valid;

    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_hi_next;
    logic [DATA_W-1:0]   w_lo_next;
    logic                w_last;
    logic                w_accept;

    // Conditional add of the multiplicand into hi (carry kept), then shift right.
    always_comb begin
        w_sum     = {1'b0, r_hi};
        w_hi_next = r_hi;
        w_lo_next = r_lo;
        if (r_lo[0]) begin
            w_sum = {1'b0, r_hi} + {1'b0, r_mcand};
        end else begin
            w_sum = {1'b0, r_hi};
        end
        w_hi_next = w_sum[DATA_W:1];
        w_lo_next = {w_sum[0], r_lo[DATA_W-1:1]};
    end

    assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_accept = (r_state == IDLE) && bus.i_valid;

    // State register; reset returns to IDLE from any state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.i_valid) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = RUN;
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, iterate in RUN, capture product on the last step.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mcand   <= {DATA_W{1'b0}};
            r_hi      <= {DATA_W{1'b0}};
            r_lo      <= {DATA_W{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_product <= {(2*DATA_W){1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mcand <= bus.i_multiplicand;
                        r_hi    <= {DATA_W{1'b0}};
                        r_lo    <= bus.i_multiplier;
                        r_cnt   <= {CNT_W{1'b0}};
                    end
                end
                RUN: begin
                    r_hi  <= w_hi_next;
                    r_lo  <= w_lo_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_product <= {w_hi_next, w_lo_next};
                    end
                end
                DONE: begin
                    r_product <= r_product;
                end
                default: begin
                    r_cnt <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Registered handshake outputs track the state being entered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_ready <= (w_next_state == IDLE);
            r_valid <= (w_next_state == DONE);
        end
    end

    assign bus.o_ready   = r_ready;
    assign bus.o_valid   = r_valid;
    assign bus.o_product = r_product;

endmodule : shift_add_multiplier

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned shift-and-add multiplier, one multiplier bit per clock.
- Computes the product that longDivision decomposes; longDivision's quotient/remainder results are verified through this block.
- Valid/ready handshake on both sides.
- Sits beside longDivision under the board top-level. Product bits can drive o_led.

Parameters:
- DATA_W, 8, operand width in bits (>= 2).
- CNT_W, $clog2(DATA_W+1), iteration counter width (derived, not overridden).

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_valid  input  1  operands present on i_multiplicand/i_multiplier.
- o_ready  output  1  block can accept operands (high only in IDLE).
- i_multiplicand  input  DATA_W  unsigned operand A.
- i_multiplier  input  DATA_W  unsigned operand B.
- o_valid  output  1  o_product holds a finished result.
- i_ready  input  1  downstream accepts the result.
- o_product  output  2*DATA_W  unsigned A*B.

Behaviour:
- Reset (sampled on an i_clk edge with i_reset=1): state=IDLE, o_ready=1, o_valid=0, o_product=0, counter=0. This applies at any time, including mid-RUN or in DONE. An in-flight result is discarded.
- IDLE:
  - o_ready=1.
  - Accept when i_valid&&o_ready at an edge.
  - On accept: latch A into the multiplicand register, load work register {carry,hi,lo} = {0, 0, B}, counter=0, go to RUN.
- RUN (o_ready=0, o_valid=0):
  - Each edge: if lo[0], then {carry,hi} = hi + A (DATA_W+1-bit add).
  - Then shift the full {carry,hi,lo} right by 1.
  - counter++.
  - When counter reaches DATA_W-1 at an edge, the final iteration completes on that edge. Go to DONE.
- DONE:
  - o_valid=1, o_product={hi,lo}, held stable until i_ready.
  - On the edge with o_valid&&i_ready, go to IDLE.
  - o_ready rises in the following cycle; no same-cycle re-accept.
- Latency: o_valid is first high in the cycle after the DATA_W-th edge following the accepting edge. That is DATA_W cycles, fixed, independent of operand values (zero operands are not shortcut).
- Throughput: one product per DATA_W+2 cycles with i_ready held high.
- Width rules:
  - The adder keeps the carry bit, so there is no overflow.
  - 2*DATA_W output is exact for all operands, max (2^W-1)^2.
- Boundary conditions:
  - i_valid while not IDLE: ignored; operands are not sampled.
  - Input changes during RUN: no effect.
  - i_ready low in DONE: hold indefinitely.
  - i_ready high outside DONE: no effect.
  - i_reset and i_valid high on the same edge: reset wins; nothing is accepted.
  - Counter wrap cannot occur; the counter is cleared on each accept.
- o_product outside DONE: holds its last value (0 after reset). Consumers qualify it with o_valid.

Decomposition:
- Package shift_add_multiplier_pkg:
  - state typedef {IDLE, RUN, DONE}.
  - Default DATA_W constant.
  - A reference multiply function for the bench.
- No sub-module. Datapath (register, adder, shifter) and FSM stay in one file, about 150 lines.
- Board top wraps it like longDivision, with tied operands, o_led = o_product[5:0].

Test Plan (DATA_W=8):
- Accept A=13, B=11 with i_ready=1 -> o_valid first high 8 cycles after the accept edge, o_product=0x008F, one-cycle o_valid, o_ready high next cycle.
- A=255, B=255 -> o_product=0xFE01 (65025); confirms carry path.
- A=0, B=200 and A=200, B=0 -> o_product=0x0000, still exactly 8-cycle latency.
- A=7, B=9 with i_ready held low 20 cycles -> o_valid and o_product=0x003F stable throughout, o_ready=0; drop occurs on the edge i_ready rises.
- i_valid pulsed with A=3, B=3 during RUN of A=5, B=6 -> result 0x001E only, second request not taken.
- i_reset asserted at RUN cycle 4 -> next cycle o_valid=0, o_product=0, o_ready=1; the new request A=2, B=4 then gives 0x0008.
